// File: rtl/tiny_dnn_seq.sv
// tiny_dnn_seq: sequencer feeding weights, bias and data into a MAC core and returning dot product plus bias
// Optional ReLU on the captured result: define TINY_DNN_SEQ_RELU_EN.
module tiny_dnn_seq #(
    parameter int f_size = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_load,
    input  logic       start_run,
    input  logic [9:0] len,
    output logic       busy,
    input  logic       in_valid,
    output logic       in_ready,
    input  real        in_data,
    output logic       r_valid,
    input  logic       r_ready,
    output real        r_data,
    output logic       init,
    output logic       write,
    output logic       bwrite,
    output logic       exec,
    output logic       bias,
    output logic [9:0] ra,
    output logic [9:0] wa,
    output real        d,
    output real        wd,
    input  real        sum
);
    typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_B, RUN, BIAS, DRAIN, RESULT} state_t;
    state_t     state_q, state_d;
    logic [9:0] len_q, len_d, k_q, k_d;
    logic       first_q, first_d;
    real        d_q, d_d, r_data_q, r_data_d, cap;
    logic       xfer, last;
    assign in_ready = (state_q == LOAD_W) || (state_q == LOAD_B) || (state_q == RUN && !first_q);
    assign xfer     = in_valid && in_ready;
    assign last     = k_q == len_q - 10'd1;
    assign busy     = state_q != IDLE;
    assign r_valid  = state_q == RESULT;
    assign init     = state_q == RUN && first_q;
    assign exec     = state_q == RUN && xfer;
    assign bias     = state_q == BIAS;
    assign write    = xfer && (state_q == LOAD_W || state_q == LOAD_B);
    assign bwrite   = xfer && state_q == LOAD_B;
    assign ra       = state_q == RUN ? k_q : 10'd0;
    assign wa       = bwrite ? 10'(f_size - 1) : (state_q == LOAD_W ? k_q : 10'd0);
    assign wd       = write ? in_data : 0.0;
    assign d        = d_q;
    assign r_data   = r_data_q;
    // result capture, optionally clamping negative sums to zero
    always_comb begin
`ifdef TINY_DNN_SEQ_RELU_EN
        cap = sum < 0.0 ? 0.0 : sum;
`else
        cap = sum;
`endif
    end
    // next-state: sequencing of load, run, bias, drain and result handshake
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        k_d      = k_q;
        first_d  = first_q;
        d_d      = d_q;
        r_data_d = r_data_q;
        case (state_q)
            IDLE: begin
                if (start_load || start_run) begin
                    len_d = len;
                    k_d   = 10'd0;
                end
                if (start_load) state_d = (len == 10'd0) ? LOAD_B : LOAD_W;
                else if (start_run) begin
                    first_d = 1'b1;
                    state_d = RUN;
                end
            end
            LOAD_W: if (xfer) begin
                k_d = k_q + 10'd1;
                if (last) state_d = LOAD_B;
            end
            LOAD_B: if (xfer) state_d = IDLE;
            RUN: begin
                if (first_q) begin
                    first_d = 1'b0;
                    if (len_q == 10'd0) state_d = BIAS;
                end else if (xfer) begin
                    k_d = k_q + 10'd1;
                    d_d = in_data;
                    if (last) state_d = BIAS;
                end
            end
            BIAS: begin
                k_d     = 10'd0;
                state_d = DRAIN;
            end
            DRAIN: begin
                k_d = k_q + 10'd1;
                if (k_q == 10'd1) begin
                    state_d  = RESULT;
                    r_data_d = cap;
                end
            end
            RESULT: if (r_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // state and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            len_q    <= 10'd0;
            k_q      <= 10'd0;
            first_q  <= 1'b0;
            d_q      <= 0.0;
            r_data_q <= 0.0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            k_q      <= k_d;
            first_q  <= first_d;
            d_q      <= d_d;
            r_data_q <= r_data_d;
        end
    end
endmodule

// File: tb/tb_tiny_dnn_seq.sv
// tb_tiny_dnn_seq: directed table-driven bench with a behavioural MAC core model
module tb_tiny_dnn_seq;
    localparam int F = 1024;
`ifdef TINY_DNN_SEQ_RELU_EN
    localparam real NEG1 = 0.0;
`else
    localparam real NEG1 = -1.0;
`endif
    logic       clk = 0, reset = 1, start_load = 0, start_run = 0, in_valid = 0, r_ready = 1;
    logic [9:0] len_in = 0;
    real        in_data = 0.0;
    logic       busy, in_ready, r_valid, init, write, bwrite, exec, bias;
    logic [9:0] ra, wa;
    real        r_data, d, wd;
    real        mem[F];
    real        acc = 0.0, w_q = 0.0, bw_q = 0.0;
    logic       exec_q = 0, bias_q = 0;
    int         cyc = 0, exec_cnt = 0, init_cnt = 0, viol = 0;
    int         checks = 0, errors = 0, c0 = 0, e0 = 0, i0 = 0;

    tiny_dnn_seq #(.f_size(F)) dut (
        .clk(clk), .reset(reset), .start_load(start_load), .start_run(start_run), .len(len_in),
        .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
        .init(init), .write(write), .bwrite(bwrite), .exec(exec), .bias(bias),
        .ra(ra), .wa(wa), .d(d), .wd(wd), .sum(acc)
    );

    always #5 clk = ~clk;

    // MAC core model: registered weight read, exec delayed one cycle, bias added one cycle after its strobe
    always @(posedge clk) begin
        if (write) mem[bwrite ? F - 1 : int'(wa)] <= wd;
        exec_q <= exec;
        bias_q <= bias;
        w_q    <= mem[int'(ra)];
        bw_q   <= mem[F - 1];
        if (init) acc <= 0.0;
        else if (exec_q) acc <= acc + w_q * d;
        else if (bias_q) acc <= acc + bw_q;
    end

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        exec_cnt <= exec_cnt + (exec ? 1 : 0);
        init_cnt <= init_cnt + (init ? 1 : 0);
        if ((init && exec) || (init && bias) || (exec && bias) || (init && exec_q)) viol <= viol + 1;
    end

    typedef struct {
        bit  ld;
        int  ll;
        real w0, w1, w2, b;
        int  rl;
        real x0, x1, x2;
        int  gap_at, gap_n;
        real exp_r;
        int  exp_lat;
    } vec_t;
    vec_t v[6];

    task automatic chk_i(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    task automatic chk_r(input string n, input real a, input real e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s: got %f expected %f", n, a, e);
        end
    endtask

    task automatic go(input bit ld, input int l);
        @(negedge clk);
        start_load = ld;
        start_run  = !ld;
        len_in     = 10'(l);
        c0 = cyc;
        e0 = exec_cnt;
        i0 = init_cnt;
        @(negedge clk);
        start_load = 0;
        start_run  = 0;
    endtask

    task automatic send(input real x);
        int n = 0;
        in_valid = 1;
        in_data  = x;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk_i("in_ready_timeout", int'(in_ready), 1);
        @(negedge clk);
    endtask

    task automatic wait_rv();
        int n = 0;
        while (!r_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk_i("r_valid_timeout", int'(r_valid), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        real xs[3];
        int  bad;
        v[0] = '{1, 3, 1.0, 2.0, 3.0, 0.5, 3, 1.0, 1.0, 2.0, -1, 0, 9.5, 8};
        v[1] = '{0, 0, 0.0, 0.0, 0.0, 0.0, 3, 1.0, 1.0, 2.0, 1, 2, 9.5, 10};
        v[2] = '{0, 0, 0.0, 0.0, 0.0, 0.0, 0, 0.0, 0.0, 0.0, -1, 0, 0.5, 5};
        v[3] = '{1, 3, 1.0, 2.0, 3.0, -10.0, 3, 1.0, 1.0, 2.0, -1, 0, NEG1, 8};
        v[4] = '{1, 2, 0.5, -2.0, 0.0, 1.0, 2, 4.0, -1.5, 0.0, -1, 0, 6.0, 7};
        v[5] = '{1, 0, 0.0, 0.0, 0.0, 2.0, 2, 2.0, 2.0, 0.0, -1, 0, NEG1, 7};
        start_run = 1;
        repeat (3) @(negedge clk);
        chk_i("rst_busy", int'(busy), 0);
        chk_i("rst_in_ready", int'(in_ready), 0);
        chk_i("rst_r_valid", int'(r_valid), 0);
        chk_i("rst_strobes", int'({init, write, bwrite, exec, bias}), 0);
        chk_i("rst_addr", int'({ra, wa}), 0);
        chk_r("rst_r_data", r_data, 0.0);
        chk_r("rst_d", d, 0.0);
        chk_r("rst_wd", wd, 0.0);
        start_run = 0;
        reset = 0;
        for (int t = 0; t < 6; t++) begin
            if (v[t].ld) begin
                go(1, v[t].ll);
                if (v[t].ll > 0) send(v[t].w0);
                if (v[t].ll > 1) send(v[t].w1);
                if (v[t].ll > 2) send(v[t].w2);
                send(v[t].b);
                in_valid = 0;
                chk_i("load_no_result", int'(r_valid), 0);
                chk_i("load_idle", int'(busy), 0);
            end
            xs[0] = v[t].x0;
            xs[1] = v[t].x1;
            xs[2] = v[t].x2;
            go(0, v[t].rl);
            for (int i = 0; i < v[t].rl; i++) begin
                if (i == v[t].gap_at) begin
                    in_valid = 0;
                    repeat (v[t].gap_n) @(negedge clk);
                end
                send(xs[i]);
            end
            in_valid = 0;
            wait_rv();
            chk_r($sformatf("v%0d_r_data", t), r_data, v[t].exp_r);
            chk_i($sformatf("v%0d_latency", t), cyc - c0, v[t].exp_lat);
            chk_i($sformatf("v%0d_exec_cnt", t), exec_cnt - e0, v[t].rl);
            chk_i($sformatf("v%0d_init_cnt", t), init_cnt - i0, 1);
            @(negedge clk);
            chk_i($sformatf("v%0d_r_valid_drop", t), int'(r_valid), 0);
        end
        // abort a run with reset, then verify a clean rerun
        go(0, 3);
        send(1.0);
        send(1.0);
        in_valid = 0;
        reset = 1;
        @(negedge clk);
        chk_i("abort_busy", int'(busy), 0);
        chk_i("abort_exec", int'(exec), 0);
        chk_r("abort_d", d, 0.0);
        chk_r("abort_r_data", r_data, 0.0);
        reset = 0;
        bad = 0;
        repeat (15) begin
            @(negedge clk);
            if (r_valid) bad++;
        end
        chk_i("abort_no_result", bad, 0);
        go(0, 3);
        send(1.0);
        send(1.0);
        send(2.0);
        in_valid = 0;
        wait_rv();
        chk_r("rerun_r_data", r_data, 6.5);
        chk_i("rerun_latency", cyc - c0, 8);
        @(negedge clk);
        // starts while busy are ignored; result held while r_ready is low
        r_ready = 0;
        go(0, 1);
        send(4.0);
        in_valid = 0;
        wait_rv();
        chk_r("hold_r_data", r_data, 4.0);
        start_run  = 1;
        start_load = 1;
        len_in     = 10'd2;
        @(negedge clk);
        start_run  = 0;
        start_load = 0;
        bad = 0;
        repeat (5) begin
            if (!r_valid || r_data != 4.0) bad++;
            @(negedge clk);
        end
        chk_i("hold_stable", bad, 0);
        r_ready = 1;
        @(negedge clk);
        chk_i("hold_accept_drop", int'(r_valid), 0);
        repeat (3) @(negedge clk);
        chk_i("busy_start_ignored", int'(busy), 0);
        chk_i("strobe_overlap", viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tiny_dnn_seq.md
TINY_DNN_SEQ -- requirements
Module: tiny_dnn_seq

Interface
REQ-001 Parameter f_size, default 1024, weight depth of the driven MAC core; the bias word lives at address f_size-1.
REQ-002 clk  in  1  single clock; all logic rising-edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 start_load  in  1  pulse: load len weights plus one bias word.
REQ-005 start_run  in  1  pulse: run a len-element dot product plus bias.
REQ-006 len  in  10  element count, sampled on an accepted start.
REQ-007 busy  out  1  high in every state except IDLE.
REQ-008 in_valid  in  1  input stream valid; carries weights or data.
REQ-009 in_ready  out  1  input stream ready.
REQ-010 in_data  in  real  weight, bias or data value.
REQ-011 r_valid  out  1  result valid.
REQ-012 r_ready  in  1  result accept.
REQ-013 r_data  out  real  dot product plus bias.
REQ-014 init, write, bwrite, exec, bias  out  1 each  core strobes.
REQ-015 ra, wa  out  10 each  core read and write addresses.
REQ-016 d, wd  out  real each  core data operand and weight write data.
REQ-017 sum  in  real  core accumulator, valid 2 cycles after the core's last exec or bias cycle.

Function
REQ-018 States are IDLE, LOAD_W, LOAD_B, RUN, BIAS, DRAIN, RESULT.
REQ-019 IDLE: start_load goes to LOAD_W, otherwise start_run goes to RUN; both high gives load priority; starts outside IDLE are ignored.
REQ-020 len=0 goes straight to LOAD_B (load) or to BIAS after init (run).
REQ-021 Transfers happen only when in_valid and in_ready are both high; in_ready is high only in LOAD_W, LOAD_B and RUN.
REQ-022 LOAD_W: the k-th transfer (k=0..len-1) drives write=1, wa=k, wd=in_data in the same cycle; the last transfer goes to LOAD_B.
REQ-023 LOAD_B: one transfer drives write=1, bwrite=1, wd=in_data, then returns to IDLE; the load produces no result.
REQ-024 RUN entry: init=1 for exactly the first RUN cycle, with exec=0 in that cycle.
REQ-025 RUN transfer k (k=0..len-1) drives exec=1, ra=k; d is registered so it equals that in_data exactly one cycle later, aligned with the core's exec delay.
REQ-026 in_valid=0 during RUN drives exec=0 (bubble); d holds and the k count does not advance.
REQ-027 After the last RUN transfer, BIAS asserts bias=1 for exactly 1 cycle, then DRAIN lasts 2 cycles.
REQ-028 At the end of DRAIN, sum is captured into r_data; if TINY_DNN_SEQ_RELU_EN is defined (REQ-035), ReLU is applied at this capture; state goes to RESULT with r_valid=1.
REQ-029 RESULT: r_valid and r_data hold until r_ready=1, then the block returns to IDLE next cycle; r_ready may be tied high.
REQ-030 Outside the cycles given above, write, bwrite, exec, bias and init are 0.
REQ-031 No two of init, exec, bias are high in the same cycle, and init never coincides with the core's delayed exec.
REQ-032 Latency with continuous in_valid and r_ready=1: start_run to r_valid = len+5 cycles.

Reset
REQ-033 reset=1 at a clock edge forces IDLE, all strobes and counters 0, r_valid=0, r_data=0.0, d=0.0, wd=0.0, ra=0, wa=0; reset has priority over start inputs.
REQ-034 Reset in mid-operation abandons the operation with no result; weights already written stay in the core; the next run's init clears the stale core sum.

Configuration
REQ-035 Macro TINY_DNN_SEQ_RELU_EN defined: a negative sum is captured as 0.0. Undefined: sum is captured unchanged.

Verification
REQ-036 Load len=3, weights 1.0, 2.0, 3.0, bias 0.5; run with data 1.0, 1.0, 2.0 -> r_data=9.5, r_valid at cycle 8 after start_run.
REQ-037 Same run with in_valid low 2 cycles between data 1 and 2 -> r_data=9.5, exec low for exactly 2 cycles, r_valid 2 cycles later.
REQ-038 Run len=0 with bias 0.5 -> r_data=0.5, no exec pulses.
REQ-039 With RELU_EN, bias -10.0 and the REQ-036 weights/data -> r_data=0.0; without it -> r_data=-1.0.
REQ-040 Reset asserted mid-RUN, then a fresh run -> no r_valid from the aborted run, and the new result is free of stale accumulation.
REQ-041 start_run pulsed while busy, and r_ready held low 5 cycles -> start ignored; r_valid and r_data stable until accepted.
